// File: rtl/dff_sync.sv
// dff_sync: resettable storage register, optionally pipelined.
// Captures data on each rising clock edge and presents it on q after STAGES
// register stages. An asynchronous active-low reset loads RESET_VALUE into
// every stage immediately and holds it while reset stays low.
//
// Optional feature (macro DFF_SYNC_RESET_SYNC_EN): reset assertion stays
// asynchronous, but release is re-timed to clock so the stages leave reset,
// and make their first capture, on the second rising edge after reset rises.
//
// Ports (positional order q, reset, clock, data):
//   q      out  WIDTH  value of the last stage (pure flop output)
//   reset  in   1      asynchronous clear, active low
//   clock  in   1      rising-edge clock
//   data   in   WIDTH  value captured by stage 0
module dff_sync #(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  output logic [WIDTH-1:0] q,
  input  logic             reset,
  input  logic             clock,
  input  logic [WIDTH-1:0] data
);

  localparam int unsigned LAST = STAGES - 1;

  // Elaboration-time guard on the supported parameter range.
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("dff_sync: WIDTH must be in 1..64");
  end
  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("dff_sync: STAGES must be in 1..8");
  end

  logic [WIDTH-1:0] stage_q [STAGES];

`ifdef DFF_SYNC_RESET_SYNC_EN
  // Release retiming: the first flop records that reset has been high for one
  // edge; the stages themselves form the second flop of the release path by
  // holding RESET_VALUE synchronously until that flop is set. Assertion still
  // clears both asynchronously.
  logic run_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Stage chain with synchronous hold until release has been retimed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else if (!run_q) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      stage_q[0] <= data;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end
`else
  // Stage chain cleared directly by reset; shifts on every edge out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      stage_q[0] <= data;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end
`endif

  // q is the last stage with no logic in between.
  assign q = stage_q[LAST];

endmodule

// File: tb/tb_dff_sync.sv
// Self-checking bench for dff_sync: a 1-bit single-stage instance and an
// 8-bit three-stage instance (RESET_VALUE 8'hA5) share clock and reset.
// A per-instance queue holds the expected stage contents; each capture pushes
// the driven value and pops the oldest, and q is compared to the queue head.
`timescale 1ns/100ps
module tb_dff_sync;

  localparam logic [7:0] RV1 = 8'hA5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       data0;
  logic       q0;
  logic [7:0] data1;
  logic [7:0] q1;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic       sb0 [$];
  logic [7:0] sb1 [$];

  dff_sync u_dut0 (
    .q     (q0),
    .reset (reset),
    .clock (clock),
    .data  (data0)
  );

  dff_sync #(
    .WIDTH       (8),
    .STAGES      (3),
    .RESET_VALUE (RV1)
  ) u_dut1 (
    .q     (q1),
    .reset (reset),
    .clock (clock),
    .data  (data1)
  );

  // Period 2: rising edges at odd times, falling edges at even times.
  always #1 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reset discards everything in flight: every stage holds its reset value.
  task automatic sb_reset();
    sb0.delete();
    sb1.delete();
    sb0.push_back(1'b0);
    for (int i = 0; i < 3; i++) sb1.push_back(RV1);
  endtask

  // Drive one data pair, take one rising edge, then compare q to the model.
  task automatic cycle(input string tag, input logic d0, input logic [7:0] d1);
    logic       e0;
    logic [7:0] e1;
    data0 = d0;
    data1 = d1;
    @(posedge clock);
    if (reset) begin
      sb0.push_back(d0);
      e0 = sb0.pop_front();
      sb1.push_back(d1);
      e1 = sb1.pop_front();
    end
    #0.5;
    check({tag, ".q0"}, 64'(q0), 64'(sb0[0]));
    check({tag, ".q1"}, 64'(q1), 64'(sb1[0]));
    @(negedge clock);
  endtask

  // Assert reset between edges and check the clear happens without an edge.
  task automatic async_reset(input string tag);
    #0.5;
    reset = 1'b0;
    sb_reset();
    #0.1;
    check({tag, ".q0"}, 64'(q0), 64'(1'b0));
    check({tag, ".q1"}, 64'(q1), 64'(RV1));
    @(negedge clock);
  endtask

  initial begin
    #5000;
    $display("FAIL timeout: simulation did not finish by t=%0t", $time);
    $fatal(1);
  end

  initial begin
    // Reset at t=0 with data 0.
    reset = 1'b0;
    data0 = 1'b0;
    data1 = 8'h00;
    sb_reset();
    #0.5;
    check("rst_t0.q0", 64'(q0), 64'(1'b0));
    check("rst_t0.q1", 64'(q1), 64'(RV1));
    cycle("rst_edge1", 1'b0, 8'h00);        // edge t=1, reset still low

    reset = 1'b1;
    cycle("run_d0", 1'b0, 8'h10);           // edge t=3
    reset = 1'b0;
    sb_reset();
    cycle("rst_over_d1", 1'b1, 8'h11);      // edge t=5, reset overrides data
    reset = 1'b1;
    cycle("run_d1", 1'b1, 8'h12);           // edge t=7, q0 becomes 1

    async_reset("async_clr");               // low at t=8.5, held across t=9

    // Three-stage pipeline from reset: A5, A5, then 01, 02, 03.
    reset = 1'b1;
    cycle("pipe_e1", 1'b1, 8'h01);
    cycle("pipe_e2", 1'b0, 8'h02);
    cycle("pipe_e3", 1'b1, 8'h03);
    cycle("pipe_e4", 1'b0, 8'hFF);
    cycle("pipe_e5", 1'b1, 8'h00);

    // Random traffic with mid-stream resets that discard in-flight data.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin
        cycle("rand", 1'($urandom_range(1)), 8'($urandom));
      end
      async_reset("rand_clr");
      reset = 1'b1;
    end
    for (int i = 0; i < 5; i++) begin
      cycle("tail", 1'($urandom_range(1)), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
